slave_rx_ctrl: RTL

Receive-side controller for the I2C slave. Runs on the oversampled slave clock and samples the SCL and SDA bus lines. It detects START and STOP conditions and counts bit times. It sequences the slave serial-in/parallel-out shift register by issuing the shift enable and the serial bit. It checks the address byte, drives ACK/NACK on SDA, and strobes each received data byte to the slave back end. Only master-write transfers are supported; any read request (R/W=1) is NACKed.

---
 rtl/slave_rx_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/slave_rx_ctrl.sv
// slave_rx_ctrl: I2C slave receive controller (START/STOP detect, bit sequencing, address check, ACK/NACK)
module slave_rx_ctrl #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       slave_scl_sixt,
    input  logic       slave_rst_n,
    input  logic       slave_scl_in,
    input  logic       slave_sda_in,
    input  logic [7:0] slave_rx_byte,
    input  logic       slave_rx_ready,
    output logic       slave_serial_bit,
    output logic       slave_rec_data_shift,
    output logic       slave_sda_oe,
    output logic       slave_addr_match,
    output logic       slave_byte_valid,
    output logic       slave_busy
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP} state_t;

    state_t                 state, state_n;
    logic [3:0]             bit_cnt, cnt_n;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_h, sda_h;
    logic                   oe_n, shift_n, match_n, busy_n, acked, acked_n;
    logic                   scl_s, sda_s, scl_rise, scl_fall, start, stop;

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start    = scl_s & scl_h & sda_h & ~sda_s;
    assign stop     = scl_s & scl_h & ~sda_h & sda_s;

    assign slave_serial_bit = sda_s;

    // Synchronise bus lines and keep one history sample for edge decoding; idle bus level is high
    always_ff @(posedge slave_scl_sixt or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], slave_scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], slave_sda_in};
            scl_h    <= scl_s;
            sda_h    <= sda_s;
        end
    end

    // State register and registered outputs
    always_ff @(posedge slave_scl_sixt or negedge slave_rst_n) begin
        if (!slave_rst_n) begin
            state                <= IDLE;
            bit_cnt              <= 4'd0;
            slave_sda_oe         <= 1'b0;
            slave_rec_data_shift <= 1'b0;
            slave_addr_match     <= 1'b0;
            slave_busy           <= 1'b0;
            acked                <= 1'b0;
        end else begin
            state                <= state_n;
            bit_cnt              <= cnt_n;
            slave_sda_oe         <= oe_n;
            slave_rec_data_shift <= shift_n;
            slave_addr_match     <= match_n;
            slave_busy           <= busy_n;
            acked                <= acked_n;
        end
    end

    // Next-state logic; STOP beats START, and both override every state
    always_comb begin
        state_n          = state;
        cnt_n            = bit_cnt;
        oe_n             = slave_sda_oe;
        shift_n          = 1'b0;
        match_n          = slave_addr_match;
        busy_n           = slave_busy;
        acked_n          = acked;
        slave_byte_valid = 1'b0;
        if (stop) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            match_n = 1'b0;
            busy_n  = 1'b0;
        end else if (start) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            match_n = 1'b0;
            busy_n  = 1'b1;
        end else begin
            case (state)
                ADDR, DATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shift_n = 1'b1;
                        cnt_n   = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        if (state == ADDR) begin
                            if (slave_rx_byte == {SLAVE_ADDR, 1'b0}) begin
                                oe_n    = 1'b1;
                                match_n = 1'b1;
                                state_n = ADDR_ACK;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end else begin
                            slave_byte_valid = 1'b1;
                            oe_n             = slave_rx_ready;
                            acked_n          = slave_rx_ready;
                            state_n          = DATA_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = DATA;
                    end
                end
                DATA_ACK: begin
                    if (scl_fall) begin
                        oe_n    = 1'b0;
                        cnt_n   = 4'd0;
                        state_n = acked ? DATA : WAIT_STOP;
                    end
                end
                WAIT_STOP: oe_n = 1'b0;
                default:   state_n = IDLE;
            endcase
        end
    end
endmodule
